multicycle_cpu: RTL

- Parametrised multi-cycle MIPS-subset core, successor to the single-cycle CPU.
- Instruction and data traffic share one unified memory port with a req/ack handshake, so memory may stall for any number of cycles.
- A control FSM sequences FETCH/DECODE/EXEC/MEM/WB and reuses one ALU per instruction.
- Adds `bne`, `lw`, `sw`, `j`, an illegal-instruction halt, and a debug register read port.

---
 rtl/multicycle_cpu.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core sharing one req/ack memory port between fetch and data.
// Define MULTICYCLE_CPU_PERF_CNT_EN to add the cycle_cnt_o / retired_cnt_o counters.
module multicycle_cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32,
   parameter int          REG_NUM  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              halt_o,
   output logic [31:0]       pc_o,
   input  logic [4:0]        dbg_addr_i,
   output logic [31:0]       dbg_data_o
`ifdef MULTICYCLE_CPU_PERF_CNT_EN
   ,
   output logic [31:0]       cycle_cnt_o,
   output logic [31:0]       retired_cnt_o
`endif
);
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t      state_q;
   logic [31:0] pc_q, ir_q, a_q, b_q, target_q, alu_q, mdr_q;
   logic [31:0] alu_d;
   logic        legal_d;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, wb_idx;
   logic [31:0] sext_imm, wb_data, addr_full;
   logic        wb_en;
   logic [31:0] gpr_rd [32];

   assign opcode   = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
   assign wb_en    = (state_q == S_WB);
   assign wb_idx   = (opcode == OP_RTYPE) ? rd : rt;
   assign wb_data  = (opcode == OP_LW) ? mdr_q : alu_q;

   // Unimplemented indices (including r0) become constant-zero read slots.
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_gpr
         if (gi >= 1 && gi < REG_NUM) begin : g_impl
            logic [31:0] reg_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
               if (rst_i)
                  reg_q <= '0;
               else if (wb_en && wb_idx == 5'(gi))
                  reg_q <= wb_data;
            end
            assign gpr_rd[gi] = reg_q;
         end else begin : g_zero
            assign gpr_rd[gi] = '0;
         end
      end
   endgenerate

   always_comb begin
      alu_d   = '0;
      legal_d = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               6'h20:   alu_d = a_q + b_q;
               6'h22:   alu_d = a_q - b_q;
               6'h24:   alu_d = a_q & b_q;
               6'h25:   alu_d = a_q | b_q;
               6'h2A:   alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
               default: legal_d = 1'b0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: alu_d = a_q + sext_imm;
         OP_SLTI:               alu_d = {31'd0, $signed(a_q) < $signed(sext_imm)};
         OP_J, OP_BEQ, OP_BNE:  legal_d = 1'b1;
         default:               legal_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         target_q <= '0;
         alu_q    <= '0;
         mdr_q    <= '0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (mem_ack_i) begin
                  ir_q    <= mem_rdata_i;
                  pc_q    <= pc_q + 32'd4;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_q      <= gpr_rd[rs];
               b_q      <= gpr_rd[rt];
               target_q <= pc_q + {sext_imm[29:0], 2'b00};
               state_q  <= S_EXEC;
            end
            S_EXEC: begin
               alu_q <= alu_d;
               if (!legal_d) begin
                  state_q <= S_HALT;
               end else begin
                  case (opcode)
                     OP_BEQ: begin
                        if (a_q == b_q) pc_q <= target_q;
                        state_q <= S_FETCH;
                     end
                     OP_BNE: begin
                        if (a_q != b_q) pc_q <= target_q;
                        state_q <= S_FETCH;
                     end
                     OP_J: begin
                        pc_q    <= {pc_q[31:28], ir_q[25:0], 2'b00};
                        state_q <= S_FETCH;
                     end
                     OP_LW, OP_SW: state_q <= S_MEM;
                     default:      state_q <= S_WB;
                  endcase
               end
            end
            S_MEM: begin
               if (mem_ack_i) begin
                  if (opcode == OP_SW) begin
                     state_q <= S_FETCH;
                  end else begin
                     mdr_q   <= mem_rdata_i;
                     state_q <= S_WB;
                  end
               end
            end
            S_WB:    state_q <= S_FETCH;
            default: state_q <= S_HALT;
         endcase
      end
   end

   // The request is gated by rst_i so it drops the instant reset is applied.
   assign mem_req_o   = !rst_i && (state_q == S_FETCH || state_q == S_MEM);
   assign mem_we_o    = (state_q == S_MEM) && (opcode == OP_SW);
   assign addr_full   = (state_q == S_MEM) ? alu_q : pc_q;
   assign mem_addr_o  = addr_full[ADDR_W-1:0];
   assign mem_wdata_o = b_q;
   assign halt_o      = (state_q == S_HALT);
   assign pc_o        = pc_q;
   assign dbg_data_o  = gpr_rd[dbg_addr_i];

`ifdef MULTICYCLE_CPU_PERF_CNT_EN
   logic [31:0] cycle_q, retired_q;
   logic        retire;

   assign retire = (state_q == S_WB)
                 || (state_q == S_MEM && mem_ack_i && opcode == OP_SW)
                 || (state_q == S_EXEC && legal_d
                     && (opcode == OP_BEQ || opcode == OP_BNE || opcode == OP_J));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cycle_q   <= '0;
         retired_q <= '0;
      end else if (state_q != S_HALT) begin
         cycle_q <= cycle_q + 32'd1;
         if (retire) retired_q <= retired_q + 32'd1;
      end
   end

   assign cycle_cnt_o   = cycle_q;
   assign retired_cnt_o = retired_q;
`endif
endmodule
